// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the sequential magnitude comparator:
//   - operand ordering modes (unsigned, two's complement, sign-magnitude)
//   - FSM state encoding
//   - one-hot result struct and a helper that applies the sign-magnitude swap
// -----------------------------------------------------------------------------
package cmp_pkg;

  // Ordering modes. Mode 3 has no name and is handled as unsigned.
  localparam logic [1:0] MODE_UNS = 2'd0;
  localparam logic [1:0] MODE_SGN = 2'd1;
  localparam logic [1:0] MODE_SM  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Exactly one field is set while a result is presented, none otherwise.
  typedef struct packed {
    logic gr;
    logic lt;
    logic eq;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = '{gr: 1'b0, lt: 1'b0, eq: 1'b0};
  localparam cmp_res_t RES_GR   = '{gr: 1'b1, lt: 1'b0, eq: 1'b0};
  localparam cmp_res_t RES_LT   = '{gr: 1'b0, lt: 1'b1, eq: 1'b0};
  localparam cmp_res_t RES_EQ   = '{gr: 1'b0, lt: 1'b0, eq: 1'b1};

  // Turns a differing-chunk verdict into a result. When both sign-magnitude
  // operands are negative, the larger magnitude is the smaller number, so the
  // verdict is mirrored.
  function automatic cmp_res_t order_res(input logic gt, input logic swap);
    return (gt ^ swap) ? RES_GR : RES_LT;
  endfunction

endpackage : cmp_pkg

// File: rtl/cmp_chunk.sv
// -----------------------------------------------------------------------------
// cmp_chunk
// Combinational unsigned comparison of one CHUNK-bit slice.
//   x, y  : slices of operand A and B
//   gt    : x > y
//   lt_o  : x < y
// Neither output set means the slices are equal.
// -----------------------------------------------------------------------------
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt_o
);

  assign gt   = (x > y);
  assign lt_o = (x < y);

endmodule : cmp_chunk

// File: rtl/comparator_seq.sv
// -----------------------------------------------------------------------------
// comparator_seq
// Sequential multi-mode magnitude comparator. Operands are captured in IDLE,
// transformed so that every mode reduces to an unsigned compare, then examined
// CHUNK bits per cycle from the MSB down, stopping at the first differing
// chunk. Sign-magnitude operands with different signs are resolved at capture.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready request handshake; in_ready is high only in IDLE
//   a, b                WIDTH-bit operands
//   mode                0 unsigned, 1 two's complement, 2 sign-magnitude,
//                       3 unsigned
//   out_valid/out_ready result handshake; result held until out_ready
//   gr, lt, eq          registered one-hot result (all 0 while !out_valid)
// -----------------------------------------------------------------------------
module comparator_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gr,
  output logic             lt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  cmp_res_t         res_q;

  logic [WIDTH-1:0] ra, rb;
  logic             swap_q;
  logic             forced_q;
  cmp_res_t         forced_res_q;

  logic             accept;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic             cap_swap;
  logic             cap_forced;
  cmp_res_t         cap_res;

  logic             chunk_gt, chunk_lt;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign gr        = res_q.gr;
  assign lt        = res_q.lt;
  assign eq        = res_q.eq;

  // Capture transform: map every mode onto an unsigned compare of ra/rb.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    cap_a      = a;
    cap_b      = b;
    cap_swap   = 1'b0;
    cap_forced = 1'b0;
    cap_res    = RES_NONE;
    case (mode)
      MODE_UNS: ;
      MODE_SGN: begin
        // Flipping the sign bit turns two's-complement order into unsigned order.
        cap_a[MSB] = ~a[MSB];
        cap_b[MSB] = ~b[MSB];
      end
      MODE_SM: begin
        if (a[MSB] != b[MSB]) begin
          cap_forced = 1'b1;
          if ((a[MSB-1:0] == '0) && (b[MSB-1:0] == '0)) begin
            cap_res = RES_EQ;              // +0 and -0 compare equal
          end else begin
            cap_res = a[MSB] ? RES_LT : RES_GR;
          end
        end else begin
          cap_a[MSB] = 1'b0;
          cap_b[MSB] = 1'b0;
          cap_swap   = a[MSB];
        end
      end
      default: ;                           // mode 3 behaves as unsigned
    endcase
  end

  // Operand and capture-side registers are only read in CMP, which is always
  // preceded by an accept that loads them.
  // NOTE: these datapath registers deliberately have no reset; the FSM
  // guarantees they are written before use, so a reset would add nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      ra           <= cap_a;
      rb           <= cap_b;
      swap_q       <= cap_swap;
      forced_q     <= cap_forced;
      forced_res_q <= cap_res;
    end
  end

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (ra[CHUNK*idx +: CHUNK]),
    .y    (rb[CHUNK*idx +: CHUNK]),
    .gt   (chunk_gt),
    .lt_o (chunk_lt)
  );

  // Control FSM with registered result outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      res_q     <= RES_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            idx   <= IDX_LAST;
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          if (forced_q) begin
            res_q     <= forced_res_q;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (chunk_gt || chunk_lt) begin
            res_q     <= order_res(chunk_gt, swap_q);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else if (idx == '0) begin
            res_q     <= RES_EQ;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            res_q     <= RES_NONE;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          res_q     <= RES_NONE;
        end
      endcase
    end
  end

endmodule : comparator_seq

// File: tb/tb_comparator_seq.sv
// -----------------------------------------------------------------------------
// tb_comparator_seq
// Directed bench for comparator_seq (WIDTH=32, CHUNK=8). A numeric model gives
// the ordering (by value in the chosen number system) and the number of chunks
// examined; a negedge compare process checks every DUT output every cycle
// against expectations the driver maintains.
// -----------------------------------------------------------------------------
module tb_comparator_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic             gr, lt, eq;

  // Expected DUT outputs, updated by the driver just after each clock edge.
  logic exp_valid, exp_gr, exp_lt, exp_eq, exp_in_ready;
  bit   chk_en;
  bit   in_rst;

  int n_checks = 0;
  int n_errors = 0;

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gr        (gr),
    .lt        (lt),
    .eq        (eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Reference model. rel: +1 A>B, -1 A<B, 0 equal, by numeric value.
  // k: chunks examined, i.e. position of the first differing chunk of the
  // order-preserving unsigned keys, counted from the top.
  function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                input logic [1:0] m, output int rel, output int k);
    longint va, vb, ma, mb;
    logic [31:0] ka, kb, d;
    int hi;
    ma = longint'({33'd0, av[30:0]});
    mb = longint'({33'd0, bv[30:0]});
    case (m)
      2'd1: begin
        va = longint'($signed(av));
        vb = longint'($signed(bv));
        ka = av ^ 32'h8000_0000;
        kb = bv ^ 32'h8000_0000;
      end
      2'd2: begin
        va = av[31] ? -ma : ma;
        vb = bv[31] ? -mb : mb;
        ka = {1'b0, av[30:0]};
        kb = {1'b0, bv[30:0]};
      end
      default: begin
        va = longint'({32'd0, av});
        vb = longint'({32'd0, bv});
        ka = av;
        kb = bv;
      end
    endcase
    rel = (va > vb) ? 1 : (va < vb) ? -1 : 0;
    d  = ka ^ kb;
    hi = -1;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] && hi < 0) hi = i;
    end
    if (m == 2'd2 && av[31] != bv[31]) k = 1;
    else if (hi < 0)                   k = NCHUNK;
    else                               k = NCHUNK - hi / CHUNK;
  endfunction

  // Compare process: every negedge, all outputs against the expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("gr",        32'(gr),        32'(exp_gr));
      check("lt",        32'(lt),        32'(exp_lt));
      check("eq",        32'(eq),        32'(exp_eq));
      if (!in_rst) check("in_ready", 32'(in_ready), 32'(exp_in_ready));
    end
  end

  task automatic clear_exp();
    exp_valid = 1'b0;
    exp_gr    = 1'b0;
    exp_lt    = 1'b0;
    exp_eq    = 1'b0;
  endtask

  // One transaction. lit_rel/lit_k are hand-computed and pin the model.
  // hold: DONE cycles with out_ready low (new requests offered meanwhile).
  // early_ready: out_ready already high during CMP, which must not matter.
  task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic [1:0] m_i, input int lit_rel, input int lit_k,
                       input int hold, input bit early_ready);
    int rel, k;
    model(a_i, b_i, m_i, rel, k);
    check("model_rel", 32'(rel), 32'(lit_rel));
    check("model_k",   32'(k),   32'(lit_k));
    @(posedge clk); #1;
    a = a_i; b = b_i; mode = m_i; in_valid = 1'b1;
    @(posedge clk); #1;                       // accept edge has passed
    in_valid     = 1'b0;
    a            = ~a_i;                      // operands only matter at accept
    b            = ~b_i;
    mode         = m_i ^ 2'd1;
    out_ready    = early_ready;
    exp_in_ready = 1'b0;
    repeat (k - 1) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;                       // k edges after accept
    exp_valid = 1'b1;
    exp_gr    = (rel > 0);
    exp_lt    = (rel < 0);
    exp_eq    = (rel == 0);
    repeat (hold) begin
      in_valid = 1'b1;                        // must be ignored in DONE
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready    = 1'b0;
    clear_exp();
    exp_in_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = 2'd0;
    clear_exp();
    exp_in_ready = 1'b1;
    in_rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    in_rst = 1'b0;
    repeat (2) @(posedge clk);

    //      a             b             mode  rel  k  hold early
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 2'd0,  1, 1, 0, 1'b0);
    do_op(32'hCCCC_CCCC, 32'hCCCC_CCCB, 2'd0,  1, 4, 0, 1'b0);
    do_op(32'h6D6D_6D6D, 32'h6D6D_6D6D, 2'd0,  0, 4, 0, 1'b0);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 2'd1, -1, 1, 0, 1'b0);
    do_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'd1, -1, 4, 0, 1'b0);
    do_op(32'h0012_0000, 32'h0011_0000, 2'd1,  1, 2, 0, 1'b1);
    do_op(32'h8000_0000, 32'h0000_0000, 2'd2,  0, 1, 0, 1'b0);
    do_op(32'hBF80_0000, 32'hC000_0000, 2'd2,  1, 1, 0, 1'b0);
    do_op(32'h3F80_0000, 32'hBF80_0000, 2'd2,  1, 1, 0, 1'b0);
    do_op(32'h8000_0001, 32'h8000_0002, 2'd2,  1, 4, 0, 1'b0);
    do_op(32'h0000_0000, 32'h8000_0001, 2'd2,  1, 1, 0, 1'b0);
    do_op(32'h0000_0100, 32'h0000_0200, 2'd3, -1, 3, 0, 1'b0);
    // Backpressure: result held for 5 cycles with new requests offered.
    do_op(32'hCCCC_CCCC, 32'hCCCC_CCCB, 2'd0,  1, 4, 5, 1'b0);

    // Reset abort during the second CMP cycle of an equal compare.
    @(posedge clk); #1;
    a = 32'h5555_5555; b = 32'h5555_5555; mode = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;                       // accepted
    in_valid = 1'b0; exp_in_ready = 1'b0;
    @(posedge clk); #1;                       // now in second CMP cycle
    rst_n = 1'b0; in_rst = 1'b1;
    clear_exp();
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_gr",        32'(gr),        32'd0);
    check("abort_lt",        32'(lt),        32'd0);
    check("abort_eq",        32'(eq),        32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    in_rst = 1'b0; exp_in_ready = 1'b1;
    repeat (6) @(posedge clk);                // no stale result may appear
    do_op(32'h0000_0001, 32'h0000_0000, 2'd0,  1, 4, 0, 1'b0);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_comparator_seq

// File: doc/comparator_seq.md
# comparator_seq

Parametrised, multi-mode sequential magnitude comparator for the CORDIC datapath. It is the successor to the fixed 32-bit combinational comparator. It compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB, and terminates early on the first differing chunk. It supports unsigned, two's-complement and sign-magnitude (IEEE-754-style) ordering. It sits between the CORDIC angle/quadrant logic and the sequencer, behind a valid/ready handshake.

## Interface
- WIDTH, 32: operand width; must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 8: bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands/mode valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode  in  2  0 = unsigned, 1 = two's complement, 2 = sign-magnitude, 3 = treated as unsigned.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- gr  out  1  A > B.
- lt  out  1  A < B.
- eq  out  1  A == B.

## Operation
- States: IDLE, CMP, DONE.
- IDLE: in_ready = 1. On in_valid, capture operands into ra/rb, set the chunk index to NCHUNK-1, and go to CMP.
- Capture transforms:
  - mode 1: invert the MSB of both operands, then compare unsigned.
  - mode 2, signs differ: resolve at capture; go to CMP with a forced result.
    - Both magnitudes zero: eq.
    - Otherwise: the operand with sign 0 is greater.
  - mode 2, signs equal: clear both sign bits and compare the magnitudes unsigned. Set a swap flag if both signs are 1.
- CMP, each cycle:
  - If a forced result exists, latch it.
  - Else compare chunk idx of ra vs rb.
    - Unequal: latch gr/lt from that chunk, with gr/lt exchanged if swap is set.
    - Equal and idx == 0: latch eq.
    - Equal and idx > 0: decrement idx and stay in CMP.
  - Any latch: go to DONE.
- DONE: out_valid = 1. gr/lt/eq stay stable until out_ready. On out_ready, clear out_valid and go to IDLE.
- Exactly one of gr/lt/eq is 1 whenever out_valid = 1. All three are 0 otherwise.
- Inputs are ignored outside IDLE; a, b and mode need only be stable in the accept cycle.

## Timing
- Reset (asynchronous assert, synchronous release by design convention):
  - State goes to IDLE.
  - out_valid, gr, lt and eq are 0.
  - in_ready = 1 once released.
- Accept happens on the edge where in_valid && in_ready.
- Latency from the accept edge to out_valid is k cycles, where k = chunks examined (1..NCHUNK).
  - Forced sign-magnitude results: k = 1.
  - Equal operands: k = NCHUNK.
- Minimum spacing between accepts is k + 2 cycles (the CMP cycles, one DONE cycle with out_ready = 1, then back in IDLE).
- out_ready may be held low indefinitely; the result must not change while held.
- out_ready high while not in DONE has no effect.
- Reset mid-CMP or mid-DONE aborts the operation; no result is emitted.
- All outputs are registered. in_ready is a decode of the state register.

## Structure
- Shared package cmp_pkg holds:
  - mode localparams MODE_UNS, MODE_SGN, MODE_SM;
  - the state encoding (IDLE, CMP, DONE).
- One combinational sub-module, cmp_chunk, is parametrised by CHUNK: inputs x and y, outputs gt and lt_o (equal when neither is set).
- Chunk selection is an indexed part-select driven by idx. idx width is $clog2(NCHUNK), minimum 1.
- Expected size is about 150–250 lines of RTL.

## Test plan
All scenarios use WIDTH = 32 and CHUNK = 8.
- Unsigned early exit: mode 0, a = 80000000, b = 7FFFFFFF → gr = 1, with out_valid 1 cycle after accept.
- Unsigned deep compare: mode 0, a = CCCCCCCC, b = CCCCCCCB → gr = 1 after 4 cycles. Separately, a = b = 6D6D6D6D → eq = 1 after 4 cycles.
- Signed: mode 1, a = 80000000, b = 7FFFFFFF → lt = 1. Separately, a = FFFFFFFE, b = FFFFFFFF → lt = 1.
- Sign-magnitude:
  - mode 2, a = 80000000, b = 00000000 → eq = 1 after 1 cycle.
  - a = BF800000, b = C0000000 → gr = 1 (swap path).
  - a = 3F800000, b = BF800000 → gr = 1.
- Backpressure: hold out_ready low for 5 cycles in DONE → out_valid and result stable, in_ready = 0, new in_valid ignored. Releasing out_ready returns to IDLE with in_ready = 1 the next cycle.
- Reset abort: assert rst_n = 0 during the 2nd CMP cycle of a = b = 55555555 → out_valid, gr, lt and eq are 0 immediately and no result follows. A subsequent compare of 00000001 vs 00000000 → gr = 1.
